usb_tx_bitstuff_nrzi: RTL

Transmit line stage directly downstream of the PISO shift register in the USB transceiver. Consumes the serial bit stream one bit per bit-time, inserts a stuffed 0 after every run of STUFF_LEN consecutive 1s, NRZI-encodes the result, and drives the differential pair. On request it appends the end-of-packet (EOP) sequence: SE0 for EOP_SE0_BITS bit-times, then J for one bit-time. Its `bit_ready` output drives the PISO's `shift_enable`, so the shifter stalls during stuffed bits.

---
 rtl/usb_tx_bitstuff_nrzi_if.sv | 25 ++
 rtl/usb_tx_bitstuff_nrzi.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/usb_tx_bitstuff_nrzi_if.sv
// Handshake and line signals of the USB transmit bit-stuff / NRZI stage.
// master = upstream/bench side, slave = the line stage itself.
interface usb_tx_bitstuff_nrzi_if;
  logic bit_tick;
  logic tx_start;
  logic bit_in;
  logic bit_valid;
  logic tx_eop;
  logic bit_ready;
  logic tx_dp;
  logic tx_dm;
  logic tx_oe;
  logic busy;
  logic underrun;

  modport master (
    output bit_tick, tx_start, bit_in, bit_valid, tx_eop,
    input  bit_ready, tx_dp, tx_dm, tx_oe, busy, underrun
  );

  modport slave (
    input  bit_tick, tx_start, bit_in, bit_valid, tx_eop,
    output bit_ready, tx_dp, tx_dm, tx_oe, busy, underrun
  );
endinterface

// File: rtl/usb_tx_bitstuff_nrzi.sv
// USB transmit line stage: bit stuffing, NRZI encoding and EOP generation.
// Define USB_TX_LOW_SPEED_EN for low-speed line polarity (J = dp 0 / dm 1).
module usb_tx_bitstuff_nrzi #(
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic                   clk,
  input  logic                   RST,
  usb_tx_bitstuff_nrzi_if.slave  bus
);

`ifdef USB_TX_LOW_SPEED_EN
  localparam logic J_DP = 1'b0;
`else
  localparam logic J_DP = 1'b1;
`endif

  localparam logic [3:0] STUFF_MAX = 4'(STUFF_LEN);
  localparam logic [2:0] SE0_MAX   = 3'(EOP_SE0_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t     state_q, state_d;
  logic       level_q, level_d;
  logic [3:0] ones_q, ones_d;
  logic [2:0] se0_q, se0_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       oe_q, oe_d;
  logic       underrun_q, underrun_d;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      level_q    <= J_DP;
      ones_q     <= '0;
      se0_q      <= '0;
      dp_q       <= J_DP;
      dm_q       <= ~J_DP;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      ones_q     <= ones_d;
      se0_q      <= se0_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      oe_q       <= oe_d;
      underrun_q <= underrun_d;
    end
  end

  // Line registers always show what the current state emits during its bit-time;
  // the first SE0 is emitted on the tick that finds the data exhausted.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    ones_d     = ones_q;
    se0_d      = se0_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    oe_d       = oe_q;
    underrun_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          state_d = S_DATA;
          oe_d    = 1'b1;
        end
      end
      S_DATA: begin
        if (bus.bit_tick) begin
          if (bus.bit_valid) begin
            if (bus.bit_in) begin
              if (ones_q < STUFF_MAX) ones_d = ones_q + 4'd1;
              if (ones_q >= STUFF_MAX - 4'd1) state_d = S_STUFF;
            end else begin
              level_d = ~level_q;
              ones_d  = '0;
            end
            dp_d = level_d;
            dm_d = ~level_d;
          end else begin
            underrun_d = ~bus.tx_eop;
            dp_d       = 1'b0;
            dm_d       = 1'b0;
            se0_d      = 3'd1;
            state_d    = S_EOP_SE0;
          end
        end
      end
      S_STUFF: begin
        if (bus.bit_tick) begin
          level_d = ~level_q;
          ones_d  = '0;
          dp_d    = ~level_q;
          dm_d    = level_q;
          state_d = S_DATA;
        end
      end
      S_EOP_SE0: begin
        if (bus.bit_tick) begin
          if (se0_q >= SE0_MAX) begin
            level_d = J_DP;
            dp_d    = J_DP;
            dm_d    = ~J_DP;
            state_d = S_EOP_J;
          end else begin
            se0_d = se0_q + 3'd1;
          end
        end
      end
      S_EOP_J: begin
        if (bus.bit_tick) begin
          oe_d    = 1'b0;
          ones_d  = '0;
          se0_d   = '0;
          level_d = J_DP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bit_ready = (state_q == S_DATA) && bus.bit_tick && bus.bit_valid && !RST;
  assign bus.tx_dp     = dp_q;
  assign bus.tx_dm     = dm_q;
  assign bus.tx_oe     = oe_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.underrun  = underrun_q;

endmodule
